// File: rtl/shift.sv
// Registered barrel shifter/rotator with carry in/out; the operation (LSL, LSR, ASR, ROR)
// is fixed at elaboration, and any unrecognised name passes the operand through unchanged.
module shift #(
  parameter  int    DATA_WIDTH = 32,
  parameter  string SHIFT_TYPE = "LSL",
  localparam int    AMT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_op,
  input  logic [AMT_W-1:0]      i_amount,
  input  logic                  i_carry,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_carry
);

  if (DATA_WIDTH < 2 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
    $error("shift: DATA_WIDTH must be a power of two and at least 2");
  end

  logic [DATA_WIDTH-1:0] shift_result;
  logic                  shift_carry;

  // The carry rides along as an extra bit, so amount 0 passes i_carry through for free
  // and the last bit shifted out lands in it for any non-zero amount.
  if (SHIFT_TYPE == "LSL") begin : g_lsl
    logic [DATA_WIDTH:0] stage [AMT_W+1];

    always_comb begin
      stage[0] = {i_carry, i_op};
      for (int k = 0; k < AMT_W; k++) begin
        stage[k+1] = i_amount[k] ? (stage[k] << (1 << k)) : stage[k];
      end
    end

    assign shift_result = stage[AMT_W][DATA_WIDTH-1:0];
    assign shift_carry  = stage[AMT_W][DATA_WIDTH];

  end else if (SHIFT_TYPE == "LSR") begin : g_lsr
    logic [DATA_WIDTH:0] stage [AMT_W+1];

    always_comb begin
      stage[0] = {i_op, i_carry};
      for (int k = 0; k < AMT_W; k++) begin
        stage[k+1] = i_amount[k] ? (stage[k] >> (1 << k)) : stage[k];
      end
    end

    assign shift_result = stage[AMT_W][DATA_WIDTH:1];
    assign shift_carry  = stage[AMT_W][0];

  end else if (SHIFT_TYPE == "ASR") begin : g_asr
    // Signed stages make >>> replicate the operand's sign bit, which is the vector MSB.
    logic signed [DATA_WIDTH:0] stage [AMT_W+1];

    always_comb begin
      stage[0] = {i_op, i_carry};
      for (int k = 0; k < AMT_W; k++) begin
        stage[k+1] = i_amount[k] ? (stage[k] >>> (1 << k)) : stage[k];
      end
    end

    assign shift_result = stage[AMT_W][DATA_WIDTH:1];
    assign shift_carry  = stage[AMT_W][0];

  end else if (SHIFT_TYPE == "ROR") begin : g_ror
    logic [DATA_WIDTH-1:0]   stage [AMT_W+1];
    logic [2*DATA_WIDTH-1:0] dbl;

    always_comb begin
      // NOTE: every variable an always_comb writes gets a value on every path first,
      // otherwise synthesis infers a latch to remember the old value.
      dbl      = '0;
      stage[0] = i_op;
      for (int k = 0; k < AMT_W; k++) begin
        dbl        = {stage[k], stage[k]} >> (1 << k);
        stage[k+1] = i_amount[k] ? dbl[DATA_WIDTH-1:0] : stage[k];
      end
    end

    assign shift_result = stage[AMT_W];
    assign shift_carry  = (i_amount != '0) ? stage[AMT_W][DATA_WIDTH-1] : i_carry;

  end else begin : g_pass
    logic amount_unused;

    assign amount_unused = ^i_amount;
    assign shift_result  = i_op;
    assign shift_carry   = i_carry;
  end

  logic                  valid_d,  valid_q;
  logic [DATA_WIDTH-1:0] result_d, result_q;
  logic                  carry_d,  carry_q;

  // Results hold while idle; only a qualified input updates them.
  always_comb begin
    valid_d  = i_valid;
    result_d = result_q;
    carry_d  = carry_q;
    if (i_valid) begin
      result_d = shift_result;
      carry_d  = shift_carry;
    end
  end

  // Reset release is expected to arrive synchronous to i_clk from the system reset
  // controller; assertion clears the outputs immediately and drops any in-flight result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      valid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_carry  = carry_q;

endmodule

// File: tb/tb_shift.sv
// Bench for shift: one instance per operation plus an unknown-name instance, all fed the
// same stimulus; a scoreboard queue holds the expected results for each driven vector.
module tb_shift;

  localparam int DW = 32;
  localparam int NI = 5;  // 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 unrecognised

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid;
  logic [DW-1:0] i_op;
  logic [4:0]    i_amount;
  logic          i_carry;

  logic          o_valid  [NI];
  logic [DW-1:0] o_result [NI];
  logic          o_carry  [NI];

  always #5 i_clk = ~i_clk;

  shift #(.DATA_WIDTH(DW), .SHIFT_TYPE("LSL")) u_lsl (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_op(i_op), .i_amount(i_amount),
    .i_carry(i_carry), .o_valid(o_valid[0]), .o_result(o_result[0]), .o_carry(o_carry[0]));
  shift #(.DATA_WIDTH(DW), .SHIFT_TYPE("LSR")) u_lsr (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_op(i_op), .i_amount(i_amount),
    .i_carry(i_carry), .o_valid(o_valid[1]), .o_result(o_result[1]), .o_carry(o_carry[1]));
  shift #(.DATA_WIDTH(DW), .SHIFT_TYPE("ASR")) u_asr (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_op(i_op), .i_amount(i_amount),
    .i_carry(i_carry), .o_valid(o_valid[2]), .o_result(o_result[2]), .o_carry(o_carry[2]));
  shift #(.DATA_WIDTH(DW), .SHIFT_TYPE("ROR")) u_ror (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_op(i_op), .i_amount(i_amount),
    .i_carry(i_carry), .o_valid(o_valid[3]), .o_result(o_result[3]), .o_carry(o_carry[3]));
  shift #(.DATA_WIDTH(DW), .SHIFT_TYPE("XYZ")) u_pass (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_op(i_op), .i_amount(i_amount),
    .i_carry(i_carry), .o_valid(o_valid[4]), .o_result(o_result[4]), .o_carry(o_carry[4]));

  typedef struct packed {
    logic [NI-1:0][DW-1:0] res;
    logic [NI-1:0]         car;
  } exp_t;

  exp_t q[$];
  exp_t last;
  logic pend_valid;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference written from the direct per-operation definitions; returns {carry, result}.
  function automatic logic [DW:0] model(int t, logic [DW-1:0] op, logic [4:0] n, logic c);
    logic [DW-1:0] r;
    logic          co;
    int            ni;
    ni = int'(n);
    if (ni == 0) return {c, op};
    case (t)
      0:       begin r = op << ni;                         co = op[DW-ni]; end
      1:       begin r = op >> ni;                         co = op[ni-1];  end
      2:       begin r = DW'($signed(op) >>> ni);          co = op[ni-1];  end
      3:       begin r = (op >> ni) | (op << (DW - ni));   co = r[DW-1];   end
      default: begin r = op;                               co = c;         end
    endcase
    return {co, r};
  endfunction

  task automatic chk(input string tag, input int idx, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_valid"},  i, DW'(o_valid[i]), '0);
      chk({tag, "_result"}, i, o_result[i],     '0);
      chk({tag, "_carry"},  i, DW'(o_carry[i]), '0);
    end
  endtask

  task automatic check_outputs(input string tag);
    if (pend_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL %s_queue: observed empty expected entry", tag);
      end else begin
        last = q.pop_front();
      end
    end
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_valid"},  i, DW'(o_valid[i]), DW'(pend_valid));
      chk({tag, "_result"}, i, o_result[i],     last.res[i]);
      chk({tag, "_carry"},  i, DW'(o_carry[i]), DW'(last.car[i]));
    end
  endtask

  // One clock per call: check what the previous edge produced, then drive the next vector.
  task automatic cycle(input string tag, input logic v, input logic [DW-1:0] op,
                       input logic [4:0] n, input logic c);
    exp_t          e;
    logic [DW:0]   m;
    @(negedge i_clk);
    check_outputs(tag);
    i_valid  = v;
    i_op     = op;
    i_amount = n;
    i_carry  = c;
    if (v) begin
      for (int i = 0; i < NI; i++) begin
        m        = model(i, op, n, c);
        e.res[i] = m[DW-1:0];
        e.car[i] = m[DW];
      end
      q.push_back(e);
    end
    pend_valid = v;
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_valid    = 1'b0;
    i_op       = '0;
    i_amount   = '0;
    i_carry    = 1'b0;
    pend_valid = 1'b0;
    last       = '0;

    #2 check_zero("reset_start");
    i_valid = 1'b1;
    i_op    = 32'hFFFF_FFFF;
    i_carry = 1'b1;
    repeat (2) @(negedge i_clk);
    check_zero("reset_held");
    i_valid = 1'b0;
    #2 i_rst_n = 1'b1;

    cycle("idle",      1'b0, 32'h0,         5'd0,  1'b0);
    cycle("lsl_1",     1'b1, 32'h8000_0001, 5'd1,  1'b0);
    cycle("shr_1",     1'b1, 32'h8000_0003, 5'd1,  1'b0);
    cycle("ror_1",     1'b1, 32'h0000_0001, 5'd1,  1'b0);
    cycle("n0_c0",     1'b1, 32'h0000_0001, 5'd0,  1'b0);
    cycle("n0_c1",     1'b1, 32'h1234_5678, 5'd0,  1'b1);
    cycle("max_amt",   1'b1, 32'hA5A5_A5A6, 5'd31, 1'b0);
    cycle("max_amt2",  1'b1, 32'h7FFF_FFFE, 5'd31, 1'b1);
    cycle("mid_amt",   1'b1, 32'hF0F0_1234, 5'd16, 1'b1);
    cycle("hold_a",    1'b0, 32'hDEAD_BEEF, 5'd7,  1'b1);
    cycle("hold_b",    1'b0, 32'h0BAD_F00D, 5'd3,  1'b0);

    for (int k = 0; k < 60; k++) begin
      cycle("rand", 1'b1, DW'($urandom), 5'($urandom_range(0, 31)), 1'($urandom));
    end

    // Reset pulse while a valid vector is waiting to be sampled: held across one edge.
    @(negedge i_clk);
    check_outputs("pre_rst");
    i_valid  = 1'b1;
    i_op     = 32'hCAFE_F00D;
    i_amount = 5'd4;
    i_carry  = 1'b1;
    #1 i_rst_n = 1'b0;
    #1 check_zero("rst_async");
    q.delete();
    last       = '0;
    pend_valid = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b0;
    #1 check_zero("rst_over_edge");
    i_rst_n = 1'b1;

    cycle("post_rst_idle", 1'b0, 32'h1111_1111, 5'd1, 1'b1);
    cycle("post_rst_idle", 1'b0, 32'h2222_2222, 5'd2, 1'b0);
    cycle("post_rst_v",    1'b1, 32'h8000_0000, 5'd31, 1'b0);
    cycle("post_rst_v",    1'b1, 32'h0000_8001, 5'd15, 1'b1);
    cycle("flush",         1'b0, 32'h0,         5'd0,  1'b0);
    cycle("flush_hold",    1'b0, 32'h0,         5'd0,  1'b0);

    n_tests++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_drained: observed %0d entries expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift.md
SHIFT -- requirements
Module: shift

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; SHALL be a power of two, at least 2.
REQ-002 Parameter SHIFT_TYPE, default "LSL", string selecting the operation: "LSL", "LSR", "ASR" or "ROR".
REQ-003 Derived AMT_W = log2(DATA_WIDTH); AMT_W is 5 for 32 bits.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 i_clk  input  1  rising-edge clock.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_valid  input  1  qualifies i_op, i_amount and i_carry this cycle.
REQ-008 i_op  input  DATA_WIDTH  operand.
REQ-009 i_amount  input  AMT_W  shift/rotate amount, unsigned, 0..DATA_WIDTH-1.
REQ-010 i_carry  input  1  incoming carry flag.
REQ-011 o_valid  output  1  o_result and o_carry are valid.
REQ-012 o_result  output  DATA_WIDTH  shifted/rotated result.
REQ-013 o_carry  output  1  carry-out flag.

Function
REQ-014 Latency SHALL be exactly 1 cycle: inputs sampled at a rising i_clk edge with i_valid=1 appear on o_result/o_carry after that edge, with o_valid=1.
REQ-015 o_valid SHALL follow i_valid delayed by one cycle; no backpressure, so one operation per cycle sustained.
REQ-016 When i_valid=0, o_result and o_carry SHALL hold their previous values.
REQ-017 For every type, amount=0 SHALL give o_result=i_op and o_carry=i_carry.
REQ-018 LSL, amount n>0: o_result=i_op<<n, zero-filled; o_carry=i_op[DATA_WIDTH-n].
REQ-019 LSR, amount n>0: o_result=i_op>>n, zero-filled; o_carry=i_op[n-1].
REQ-020 ASR, amount n>0: o_result=i_op>>n filled with i_op[DATA_WIDTH-1]; o_carry=i_op[n-1].
REQ-021 ROR, amount n>0: o_result=(i_op>>n)|(i_op<<(DATA_WIDTH-n)); o_carry=o_result[DATA_WIDTH-1].
REQ-022 Equivalently, LSL is {carry,result}={i_carry,i_op}<<n, LSR is {result,carry}={i_op,i_carry}>>n, and ASR is the same with an arithmetic shift.
REQ-023 Maximum amount DATA_WIDTH-1 SHALL be handled exactly, e.g. LSL 31 gives o_carry=i_op[1].
REQ-024 An unrecognised SHIFT_TYPE SHALL give pass-through: o_result=i_op, o_carry=i_carry.
REQ-025 SHIFT_TYPE is resolved at elaboration; only the selected datapath SHALL be built.
REQ-026 The datapath SHALL be a log2(DATA_WIDTH)-stage barrel shifter; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-027 While i_rst_n=0, o_valid, o_result and o_carry SHALL be 0, taking effect asynchronously without waiting for a clock edge.
REQ-028 Deasserting i_rst_n SHALL be synchronised to i_clk; the first valid output follows the first edge sampling i_valid=1 after release.
REQ-029 Reset asserted mid-stream SHALL discard the in-flight result; no output appears for it after release.

Verification
REQ-030 LSL, i_op=0x80000001, n=1, i_carry=0 -> o_result=0x00000002, o_carry=1, o_valid=1 one cycle later.
REQ-031 LSR/ASR, i_op=0x80000003, n=1 -> LSR 0x40000001, o_carry=1; ASR 0xC0000001, o_carry=1.
REQ-032 ROR, i_op=0x00000001, n=1 -> o_result=0x80000000, o_carry=1; ROR n=0, i_carry=0 -> o_result=i_op, o_carry=0.
REQ-033 All four types, i_op=0x12345678, n=0, i_carry=1 -> o_result=0x12345678, o_carry=1.
REQ-034 Back-to-back valid inputs every cycle, plus a pulse of i_rst_n low between clock edges -> outputs 0 immediately, and o_valid=0 until new input is sampled.
REQ-035 At least 50 random (i_op, i_amount, i_carry) vectors per type SHALL match the REQ-022 and REQ-021 models.
